// File: rtl/conv_dim1.sv
// Registered GF(2) convolution stage: out = in * kernel as a carry-less polynomial product,
// produced one clock after in_valid with a matching out_valid flag.
module conv_dim1 #(
    parameter int IN_W  = 255,
    parameter int KER_W = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    input  logic [IN_W-1:0]             in,
    input  logic [KER_W-1:0]            kernel,
    output logic [IN_W+KER_W-2:0]       out,
    output logic                        out_valid
);

    localparam int OUT_W = IN_W + KER_W - 1;

    logic [OUT_W-1:0] conv_d;
    logic [OUT_W-1:0] out_q;
    logic             out_valid_q;

    // Each output bit is the parity of every in/kernel product landing on it; taps that fall
    // off either end of the input are tied to zero at elaboration time.
    for (genvar n = 0; n < OUT_W; n++) begin : g_out
        logic [KER_W-1:0] terms;
        for (genvar k = 0; k < KER_W; k++) begin : g_tap
            if ((n - k) >= 0 && (n - k) <= (IN_W - 1)) begin : g_in_range
                assign terms[k] = in[n-k] & kernel[k];
            end else begin : g_pad
                assign terms[k] = 1'b0;
            end
        end
        assign conv_d[n] = ^terms;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                out_q <= conv_d;
            end
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_conv_dim1.sv
// Self-checking bench for conv_dim1: directed vectors plus random traffic compared against a
// shift-and-xor polynomial product model.
module tb_conv_dim1;

    localparam int IN_W  = 255;
    localparam int KER_W = 3;
    localparam int OUT_W = IN_W + KER_W - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic [IN_W-1:0]  in_s;
    logic [KER_W-1:0] ker_s;
    logic [OUT_W-1:0] out_s;
    logic             out_valid_s;

    int n_checks = 0;
    int n_fail   = 0;

    logic [OUT_W-1:0] exp_out;
    logic             exp_valid;
    logic [IN_W-1:0]  vec;
    logic [KER_W-1:0] kv;
    logic             vv;

    conv_dim1 #(.IN_W(IN_W), .KER_W(KER_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in       (in_s),
        .kernel   (ker_s),
        .out      (out_s),
        .out_valid(out_valid_s)
    );

    always #5 clk = ~clk;

    // Carry-less product: XOR in the input shifted by each set kernel tap.
    function automatic logic [OUT_W-1:0] model(input logic [IN_W-1:0] a,
                                               input logic [KER_W-1:0] k);
        logic [OUT_W-1:0] acc;
        logic [OUT_W-1:0] ext;
        acc = '0;
        ext = OUT_W'(a);
        for (int t = 0; t < KER_W; t++) begin
            if (k[t]) acc = acc ^ (ext << t);
        end
        return acc;
    endfunction

    function automatic logic [IN_W-1:0] rand_vec();
        logic [IN_W-1:0] r;
        for (int i = 0; i < IN_W; i++) r[i] = 1'($urandom & 1);
        return r;
    endfunction

    task automatic check(input string tag, input logic [OUT_W-1:0] obs,
                         input logic [OUT_W-1:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Drive one cycle of stimulus at the falling edge, then sample just after the rising edge.
    task automatic step(input logic v, input logic [IN_W-1:0] a, input logic [KER_W-1:0] k);
        @(negedge clk);
        in_valid = v;
        in_s     = a;
        ker_s    = k;
        @(posedge clk);
        #1;
        if (v) exp_out = model(a, k);
        exp_valid = v;
    endtask

    task automatic check_both(input string tag);
        check({tag, "_out"}, out_s, exp_out);
        check({tag, "_valid"}, OUT_W'(out_valid_s), OUT_W'(exp_valid));
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_s     = rand_vec();
        ker_s    = 3'($urandom);

        // Reset held over live clock edges with valid input present.
        repeat (3) @(posedge clk);
        #1;
        check("reset_out", out_s, '0);
        check("reset_valid", OUT_W'(out_valid_s), '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reference vector.
        step(1'b1, IN_W'(20'hD558F), 3'b101);
        check("ref_const", out_s, OUT_W'(24'h3803B3));
        check_both("ref");

        // Identity and zero kernels.
        vec = rand_vec();
        step(1'b1, vec, 3'b001);
        check("identity", out_s, {2'b00, vec});
        check_both("identity_model");
        step(1'b1, rand_vec(), 3'b000);
        check("zero_kernel", out_s, '0);
        check("zero_kernel_valid", OUT_W'(out_valid_s), OUT_W'(1));

        // Edge bits with all-ones input and kernel.
        step(1'b1, '1, 3'b111);
        exp_out      = '1;
        exp_out[1]   = 1'b0;
        exp_out[255] = 1'b0;
        check("edges_vec", out_s, exp_out);
        check("edge_b0", OUT_W'(out_s[0]), OUT_W'(1));
        check("edge_b1", OUT_W'(out_s[1]), OUT_W'(0));
        check("edge_b255", OUT_W'(out_s[255]), OUT_W'(0));
        check("edge_b256", OUT_W'(out_s[256]), OUT_W'(1));

        // Back-to-back stream, then idle cycles with junk inputs hold the last result.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, rand_vec(), 3'($urandom));
            check_both("stream");
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, rand_vec(), 3'($urandom));
            check_both("hold");
        end

        // Asynchronous reset mid-stream, away from any clock edge.
        step(1'b1, rand_vec(), 3'($urandom));
        check_both("pre_reset");
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_out", out_s, '0);
        check("async_reset_valid", OUT_W'(out_valid_s), '0);
        @(negedge clk);
        rst_n   = 1'b1;
        exp_out = '0;
        step(1'b1, rand_vec(), 3'($urandom));
        check_both("post_reset");

        // Random traffic with random valid gaps.
        for (int i = 0; i < 40; i++) begin
            vv  = 1'($urandom_range(0, 3) != 0);
            vec = rand_vec();
            kv  = 3'($urandom);
            step(vv, vec, kv);
            check_both("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
